// File: rtl/ch0re_pl_ctrl_if.sv
// ch0re_pl_ctrl_if: hazard/redirect requests in, pipeline strobes and perf counters out.
interface ch0re_pl_ctrl_if #(parameter int CNT_W = 32);
  logic             id_valid;
  logic             ld_use_stall;
  logic             illegal;
  logic             br_taken;
  logic             mem_busy;
  logic             resume;
  logic             cnt_clr;
  logic             pc_en;
  logic             pc_sel_br;
  logic             ifid_en;
  logic             idex_en;
  logic             exmem_en;
  logic             memwb_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic             halted;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  modport master (
    output id_valid, ld_use_stall, illegal, br_taken, mem_busy, resume, cnt_clr,
    input  pc_en, pc_sel_br, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, halted, state, stall_cnt, flush_cnt
  );
  modport slave (
    input  id_valid, ld_use_stall, illegal, br_taken, mem_busy, resume, cnt_clr,
    output pc_en, pc_sel_br, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, halted, state, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/ch0re_pl_ctrl.sv
// ch0re_pl_ctrl: five-stage pipeline enables/flushes, illegal-instruction drain/halt/resume, saturating perf counters.
module ch0re_pl_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 32
) (
  input logic          clk,
  input logic          rst_n,
  ch0re_pl_ctrl_if.slave pl
);
  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, HALT = 2'd2, RESUME = 2'd3} state_t;
  state_t           state_q, state_d;
  logic [3:0]       dcnt_q, dcnt_d;
  logic [CNT_W-1:0] stall_q, flush_q;
  logic             stall_inc, flush_inc;
  logic [4:0]       en;
  logic [2:0]       fl;
  // en = {pc, ifid, idex, exmem, memwb}; fl = {pc_sel_br, ifid_flush, idex_flush}
  always_comb begin
    state_d   = state_q;
    dcnt_d    = dcnt_q;
    en        = '0;
    fl        = '0;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    if (rst_n) begin
      case (state_q)
        RUN: begin
          if (pl.mem_busy) begin
            stall_inc = 1'b1;
          end else if (pl.br_taken) begin
            en        = 5'b11111;
            fl        = 3'b111;
            flush_inc = 1'b1;
          end else if (pl.illegal && pl.id_valid) begin
            en      = 5'b00111;
            fl      = 3'b001;
            state_d = DRAIN;
            dcnt_d  = 4'(DRAIN_CYCLES);
          end else if (pl.ld_use_stall) begin
            en        = 5'b00111;
            fl        = 3'b001;
            stall_inc = 1'b1;
          end else begin
            en = 5'b11111;
          end
        end
        DRAIN: begin
          if (!pl.mem_busy) begin
            en      = 5'b00111;
            fl      = 3'b001;
            dcnt_d  = dcnt_q - 4'd1;
            state_d = (dcnt_q == 4'd1) ? HALT : DRAIN;
          end
        end
        HALT: state_d = pl.resume ? RESUME : HALT;
        RESUME: begin
          en      = 5'b01111;
          fl      = 3'b010;
          state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      dcnt_q  <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      stall_q <= pl.cnt_clr ? '0 : (stall_inc && !(&stall_q)) ? stall_q + CNT_W'(1) : stall_q;
      flush_q <= pl.cnt_clr ? '0 : (flush_inc && !(&flush_q)) ? flush_q + CNT_W'(1) : flush_q;
    end
  end
  assign {pl.pc_en, pl.ifid_en, pl.idex_en, pl.exmem_en, pl.memwb_en} = en;
  assign {pl.pc_sel_br, pl.ifid_flush, pl.idex_flush} = fl;
  assign pl.halted    = (state_q == HALT);
  assign pl.state     = state_q;
  assign pl.stall_cnt = stall_q;
  assign pl.flush_cnt = flush_q;
endmodule

// File: tb/tb_ch0re_pl_ctrl.sv
// tb_ch0re_pl_ctrl: directed vectors with hand-computed strobes, states and counter values.
module tb_ch0re_pl_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int   n_run = 0;
  int   n_fail = 0;
  localparam logic [6:0] V = 7'd64, L = 7'd32, I = 7'd16, B = 7'd8, M = 7'd4, R = 7'd2, C = 7'd1;
  always #5 clk = ~clk;
  ch0re_pl_ctrl_if #(.CNT_W(32)) a ();
  ch0re_pl_ctrl_if #(.CNT_W(2))  s ();
  ch0re_pl_ctrl #(.DRAIN_CYCLES(3), .CNT_W(32)) u_dut (.clk(clk), .rst_n(rst_n), .pl(a.slave));
  ch0re_pl_ctrl #(.DRAIN_CYCLES(3), .CNT_W(2))  u_sat (.clk(clk), .rst_n(rst_n), .pl(s.slave));
  assign s.id_valid     = a.id_valid;
  assign s.ld_use_stall = a.ld_use_stall;
  assign s.illegal      = a.illegal;
  assign s.br_taken     = a.br_taken;
  assign s.mem_busy     = a.mem_busy;
  assign s.resume       = a.resume;
  assign s.cnt_clr      = a.cnt_clr;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic [6:0] v);
    @(negedge clk);
    {a.id_valid, a.ld_use_stall, a.illegal, a.br_taken, a.mem_busy, a.resume, a.cnt_clr} = v;
    #1;
  endtask
  function automatic logic [4:0] en();
    return {a.pc_en, a.ifid_en, a.idex_en, a.exmem_en, a.memwb_en};
  endfunction
  function automatic logic [2:0] fl();
    return {a.pc_sel_br, a.ifid_flush, a.idex_flush};
  endfunction
  initial begin
    rst_n = 1'b0;
    {a.id_valid, a.ld_use_stall, a.illegal, a.br_taken, a.mem_busy, a.resume, a.cnt_clr} = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_en", 64'(en()), 64'h0);
    check("rst_fl", 64'(fl()), 64'h0);
    check("rst_halted", 64'(a.halted), 64'h0);
    check("rst_state", 64'(a.state), 64'h0);
    check("rst_stall", 64'(a.stall_cnt), 64'h0);
    check("rst_flush", 64'(a.flush_cnt), 64'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(0);
      check("idle_en", 64'(en()), 64'h1f);
    end
    drive(0);
    check("idle_stall", 64'(a.stall_cnt), 64'h0);
    check("idle_flush", 64'(a.flush_cnt), 64'h0);
    drive(L);
    check("lu_en", 64'(en()), 64'h07);
    check("lu_fl", 64'(fl()), 64'h1);
    drive(0);
    check("lu_stall", 64'(a.stall_cnt), 64'h1);
    drive(B | I | V);
    check("brill_en", 64'(en()), 64'h1f);
    check("brill_fl", 64'(fl()), 64'h7);
    drive(0);
    check("brill_state", 64'(a.state), 64'h0);
    check("brill_flush", 64'(a.flush_cnt), 64'h1);
    drive(R);
    check("res_run_state", 64'(a.state), 64'h0);
    check("res_run_en", 64'(en()), 64'h1f);
    drive(0);
    check("res_run_next", 64'(a.state), 64'h0);
    drive(C);
    drive(0);
    check("clr_stall", 64'(a.stall_cnt), 64'h0);
    check("clr_flush", 64'(a.flush_cnt), 64'h0);
    repeat (2) begin
      drive(B | M);
      check("brbusy_en", 64'(en()), 64'h0);
      check("brbusy_fl", 64'(fl()), 64'h0);
    end
    drive(B);
    check("br3_en", 64'(en()), 64'h1f);
    check("br3_fl", 64'(fl()), 64'h7);
    drive(0);
    check("brbusy_stall", 64'(a.stall_cnt), 64'h2);
    check("brbusy_flush", 64'(a.flush_cnt), 64'h1);
    drive(I | V);
    check("c5_state", 64'(a.state), 64'h0);
    check("c5_en", 64'(en()), 64'h07);
    check("c5_fl", 64'(fl()), 64'h1);
    drive(R);
    check("c6_state", 64'(a.state), 64'h1);
    check("c6_en", 64'(en()), 64'h07);
    drive(M);
    check("c7_state", 64'(a.state), 64'h1);
    check("c7_en", 64'(en()), 64'h0);
    drive(0);
    check("c8_state", 64'(a.state), 64'h1);
    check("c8_en", 64'(en()), 64'h07);
    drive(0);
    check("c9_state", 64'(a.state), 64'h1);
    check("c9_halted", 64'(a.halted), 64'h0);
    drive(0);
    check("c10_state", 64'(a.state), 64'h2);
    check("c10_halted", 64'(a.halted), 64'h1);
    check("c10_en", 64'(en()), 64'h0);
    drive(I | V | B);
    check("c11_state", 64'(a.state), 64'h2);
    check("c11_en", 64'(en()), 64'h0);
    check("c11_fl", 64'(fl()), 64'h0);
    drive(R);
    check("c12_state", 64'(a.state), 64'h2);
    drive(0);
    check("c13_state", 64'(a.state), 64'h3);
    check("c13_en", 64'(en()), 64'h0f);
    check("c13_fl", 64'(fl()), 64'h2);
    check("c13_halted", 64'(a.halted), 64'h0);
    drive(0);
    check("c14_state", 64'(a.state), 64'h0);
    check("c14_en", 64'(en()), 64'h1f);
    check("drain_stall", 64'(a.stall_cnt), 64'h2);
    check("drain_flush", 64'(a.flush_cnt), 64'h1);
    drive(I | V);
    repeat (4) drive(0);
    check("halt2", 64'(a.halted), 64'h1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("hrst_en", 64'(en()), 64'h0);
    check("hrst_fl", 64'(fl()), 64'h0);
    check("hrst_halted", 64'(a.halted), 64'h0);
    check("hrst_state", 64'(a.state), 64'h0);
    check("hrst_stall", 64'(a.stall_cnt), 64'h0);
    check("hrst_flush", 64'(a.flush_cnt), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_state", 64'(a.state), 64'h0);
    check("post_en", 64'(en()), 64'h1f);
    repeat (5) drive(L);
    drive(0);
    check("sat_wide", 64'(a.stall_cnt), 64'h5);
    check("sat_narrow", 64'(s.stall_cnt), 64'h3);
    drive(L | C);
    drive(0);
    check("clrpri_wide", 64'(a.stall_cnt), 64'h0);
    check("clrpri_narrow", 64'(s.stall_cnt), 64'h0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
